// File: rtl/majority_pkg.sv
// Shared types for the majority oversampler front-end.
// Window width, FSM states and the packed window type.
package majority_pkg;

    localparam int NSAMP = 7;

    typedef enum logic {
        IDLE,
        SAMPLE
    } state_t;

    typedef logic [NSAMP-1:0] win_t;

endpackage

// File: rtl/maj7_vote.sv
// Combinational 7-input majority: 1 when four or more inputs are set.
module maj7_vote
    import majority_pkg::*;
(
    input  win_t win,
    output logic vote
);

    logic [2:0] ones;

    always_comb begin
        ones = '0;
        for (int i = 0; i < NSAMP; i++) begin
            ones = ones + 3'(win[i]);
        end
        vote = (ones >= 3'd4);
    end

endmodule

// File: rtl/majority_oversampler.sv
// Oversampling window packer with registered majority and valid/ready output.
// Optional MAJ_DISAGREE_CNT_EN adds a saturating count of mixed windows.
module majority_oversampler
    import majority_pkg::*;
#(
    parameter int DIV   = 4,
    parameter int PRE_W = $clog2(DIV + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             en,
    input  logic             ovr_clr,
    output logic [NSAMP-1:0] win_data,
    output logic             bit_out,
    output logic             win_valid,
    input  logic             win_ready,
    output logic             overrun
`ifdef MAJ_DISAGREE_CNT_EN
    ,
    output logic [7:0]       disagree_cnt
`endif
);

    localparam logic [2:0]       LAST = 3'(NSAMP - 1);
    localparam logic [PRE_W-1:0] PMAX = PRE_W'(DIV - 1);

    logic             sync1, sync2;
    state_t           state, state_nxt;
    logic [PRE_W-1:0] pre, pre_nxt;
    logic [2:0]       idx, idx_nxt;
    win_t             asm_q, asm_nxt;
    logic             tick;
    logic             done;
    logic             vote;
    logic             load;
    logic             drop;
    logic             xfer;

    always_comb begin
        state_nxt = state;
        pre_nxt   = pre;
        idx_nxt   = idx;
        asm_nxt   = asm_q;
        tick      = 1'b0;
        unique case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = SAMPLE;
                    pre_nxt   = '0;
                    idx_nxt   = '0;
                end
            end
            SAMPLE: begin
                if (!en) begin
                    state_nxt = IDLE;
                    pre_nxt   = '0;
                    idx_nxt   = '0;
                    asm_nxt   = '0;
                end else begin
                    tick    = (pre == PMAX);
                    pre_nxt = tick ? '0 : pre + PRE_W'(1);
                    if (tick) begin
                        asm_nxt[idx] = sync2;
                        idx_nxt = (idx == LAST) ? '0 : idx + 3'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // asm_nxt already carries the sample taken on the completing tick
    assign done = tick && (idx == LAST);
    assign xfer = win_valid && win_ready;
    assign load = done && (!win_valid || win_ready);
    assign drop = done && win_valid && !win_ready;

    maj7_vote u_vote (
        .win  (asm_nxt),
        .vote (vote)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= IDLE;
            pre   <= '0;
            idx   <= '0;
            asm_q <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            state <= state_nxt;
            pre   <= pre_nxt;
            idx   <= idx_nxt;
            asm_q <= asm_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_data  <= '0;
            bit_out   <= 1'b0;
            win_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                win_data  <= asm_nxt;
                bit_out   <= vote;
                win_valid <= 1'b1;
            end else if (xfer) begin
                win_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef MAJ_DISAGREE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disagree_cnt <= '0;
        end else if (load && asm_nxt != '0 && asm_nxt != '1
                     && disagree_cnt != 8'hFF) begin
            disagree_cnt <= disagree_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_majority_oversampler.sv
// Self-checking bench for majority_oversampler (DIV=2).
// Directed scenarios plus random traffic against a behavioural model.
module tb_majority_oversampler;

    localparam int DIV = 2;
    localparam int HN  = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       en;
    logic       ovr_clr;
    logic       win_ready;
    logic [6:0] win_data;
    logic       bit_out;
    logic       win_valid;
    logic       overrun;
`ifdef MAJ_DISAGREE_CNT_EN
    logic [7:0] disagree_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: samples are din values seen two edges earlier,
    // taken every DIV edges after the SAMPLE entry edge.
    bit         hist [HN];
    int         m_e;
    bit         m_on;
    int         m_n;
    logic [6:0] m_win;
    logic [6:0] m_data;
    bit         m_bit;
    bit         m_valid;
    bit         m_ovr;
    int         m_cnt;

    majority_oversampler #(.DIV(DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .en           (en),
        .ovr_clr      (ovr_clr),
        .win_data     (win_data),
        .bit_out      (bit_out),
        .win_valid    (win_valid),
        .win_ready    (win_ready),
        .overrun      (overrun)
`ifdef MAJ_DISAGREE_CNT_EN
        ,
        .disagree_cnt (disagree_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < HN; i++) hist[i] = 1'b0;
        m_e = 0; m_on = 1'b0; m_n = 0; m_win = '0;
        m_data = '0; m_bit = 1'b0; m_valid = 1'b0;
        m_ovr = 1'b0; m_cnt = 0;
    endtask

    task automatic model_edge();
        bit         smp;
        bit         done;
        bit         drop;
        int         k;
        logic [6:0] cand;
        smp  = (m_e >= 2) ? hist[(m_e - 2) % HN] : 1'b0;
        hist[m_e % HN] = din;
        m_e++;
        done = 1'b0;
        cand = '0;
        if (!m_on) begin
            if (en) begin m_on = 1'b1; m_n = 0; end
        end else if (!en) begin
            m_on = 1'b0; m_win = '0;
        end else begin
            m_n++;
            if (m_n % DIV == 0) begin
                k = (m_n / DIV - 1) % 7;
                m_win[k] = smp;
                if (k == 6) begin done = 1'b1; cand = m_win; end
            end
        end
        drop = done && m_valid && !win_ready;
        if (done && (!m_valid || win_ready)) begin
            m_data  = cand;
            m_bit   = ($countones(cand) >= 4);
            m_valid = 1'b1;
            if (cand != 7'h00 && cand != 7'h7F && m_cnt < 255) m_cnt++;
        end else if (m_valid && win_ready) begin
            m_valid = 1'b0;
        end
        if (drop) m_ovr = 1'b1;
        else if (ovr_clr) m_ovr = 1'b0;
    endtask

    task automatic check_all();
        chk("win_valid", {7'b0, win_valid}, {7'b0, m_valid});
        chk("win_data", {1'b0, win_data}, {1'b0, m_data});
        chk("bit_out", {7'b0, bit_out}, {7'b0, m_bit});
        chk("overrun", {7'b0, overrun}, {7'b0, m_ovr});
`ifdef MAJ_DISAGREE_CNT_EN
        chk("disagree_cnt", disagree_cnt, 8'(m_cnt));
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic goto_n(input int t);
        for (int i = 0; i < 4000 && m_n < t; i++) cycle();
    endtask

    task automatic restart();
        en = 1'b0;
        cycle();
        en = 1'b1;
        cycle();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, {7'b0, win_valid}, 8'h00);
        chk({tag, "_data"}, {1'b0, win_data}, 8'h00);
        chk({tag, "_bit"}, {7'b0, bit_out}, 8'h00);
        chk({tag, "_ovr"}, {7'b0, overrun}, 8'h00);
`ifdef MAJ_DISAGREE_CNT_EN
        chk({tag, "_cnt"}, disagree_cnt, 8'h00);
`endif
    endtask

    logic [6:0] p1;
    logic [6:0] p2;

    initial begin
        rst = 1'b1; din = 1'b0; en = 1'b0;
        ovr_clr = 1'b0; win_ready = 1'b1;
        model_reset();
        #1;
        chk_zero("reset");
        #1;
        rst = 1'b0;

        // 1: constant ones, first window 14 edges after entry
        din = 1'b1;
        restart();
        goto_n(13);
        chk("t1_early", {7'b0, win_valid}, 8'h00);
        goto_n(14);
        chk("t1_valid", {7'b0, win_valid}, 8'h01);
        chk("t1_data", {1'b0, win_data}, 8'h7F);
        chk("t1_bit", {7'b0, bit_out}, 8'h01);
        goto_n(28);
        chk("t1_repeat", {7'b0, win_valid}, 8'h01);

        // 2: tick-aligned patterns
        p1 = 7'b1001011;
        p2 = 7'b0110100;
        din = p1[0];
        en = 1'b0;
        cycle();
        en = 1'b1;
        for (int i = 0; i <= 28; i++) begin
            if (i < 14) din = p1[(i % 14) / 2];
            else        din = p2[(i % 14) / 2];
            cycle();
            if (i == 14) begin
                chk("t2_win1", {1'b0, win_data}, 8'h4B);
                chk("t2_bit1", {7'b0, bit_out}, 8'h01);
            end
            if (i == 28) begin
                chk("t2_win2", {1'b0, win_data}, 8'h34);
                chk("t2_bit2", {7'b0, bit_out}, 8'h00);
            end
        end

        // 3: backpressure and overrun
        din = 1'b1;
        en = 1'b0;
        win_ready = 1'b1;
        cycle();
        win_ready = 1'b0;
        en = 1'b1;
        cycle();
        goto_n(14);
        chk("t3_first", {1'b0, win_data}, 8'h7F);
        goto_n(27);
        chk("t3_hold", {7'b0, win_valid}, 8'h01);
        chk("t3_noovr", {7'b0, overrun}, 8'h00);
        goto_n(28);
        chk("t3_ovr", {7'b0, overrun}, 8'h01);
        goto_n(29);
        ovr_clr = 1'b1;
        cycle();
        ovr_clr = 1'b0;
        chk("t3_clr", {7'b0, overrun}, 8'h00);
        goto_n(41);
        ovr_clr = 1'b1;
        cycle();
        ovr_clr = 1'b0;
        chk("t3_setwins", {7'b0, overrun}, 8'h01);

        // 4: ready on the completing tick
        ovr_clr = 1'b1;
        din = 1'b0;
        cycle();
        ovr_clr = 1'b0;
        goto_n(55);
        win_ready = 1'b1;
        cycle();
        win_ready = 1'b0;
        chk("t4_valid", {7'b0, win_valid}, 8'h01);
        chk("t4_ovr", {7'b0, overrun}, 8'h00);
        chk("t4_data", {1'b0, win_data}, 8'h01);

        // 5a: asynchronous reset mid-window
        goto_n(62);
        rst = 1'b1;
        #1;
        chk_zero("t5_rst");
        model_reset();
        #1;
        rst = 1'b0;

        // 5b: enable drop with a pending window
        din = 1'b1;
        win_ready = 1'b0;
        restart();
        goto_n(20);
        en = 1'b0;
        din = 1'b0;
        cycle();
        chk("t5_pending", {7'b0, win_valid}, 8'h01);
        win_ready = 1'b1;
        cycle();
        chk("t5_xfer", {7'b0, win_valid}, 8'h00);
        en = 1'b1;
        cycle();
        goto_n(13);
        chk("t5_noearly", {7'b0, win_valid}, 8'h00);
        goto_n(14);
        chk("t5_fresh", {7'b0, win_valid}, 8'h01);
        chk("t5_zero", {1'b0, win_data}, 8'h00);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            din       = 1'($urandom % 2);
            en        = ($urandom % 60) != 0;
            win_ready = ($urandom % 3) != 0;
            ovr_clr   = ($urandom % 20) == 0;
            cycle();
        end
        ovr_clr = 1'b0;

`ifdef MAJ_DISAGREE_CNT_EN
        // 6: counter saturation with alternating windows
        win_ready = 1'b1;
        din = 1'b1;
        en = 1'b0;
        cycle();
        en = 1'b1;
        for (int i = 0; i <= 14 * 560; i++) begin
            if ((i / 14) % 2 == 0) din = 1'b1;
            else din = ((i % 14) / 2) < 3;
            cycle();
        end
        chk("t6_sat", disagree_cnt, 8'hFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
